preg_free_list: RTL and testbench
=================================

# preg_free_list

Physical-register free list feeding the two-wide uop decode/rename stage. Each cycle it hands out up to two free physical registers (preg1/preg2) to the two decode slots and accepts up to two released registers from retirement. It keeps a speculative allocation head and a committed head, so a pipeline clear rolls allocations back to the last retired point.

## Interface
- NUM_PREGS, 64: physical registers; power of two, ≥ NUM_AREGS+2
- NUM_AREGS, 16: architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset and never start on the list
- PW = $clog2(NUM_PREGS) (derived)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  pipeline flush; rolls back speculative allocations
- alloc_req  in  2  bit0 = decode slot 1 wants a preg, bit1 = slot 2
- alloc_grant  out  1  every requested slot is served this cycle (all-or-nothing)
- preg1  out  PW  preg for slot 1
- preg2  out  PW  preg for slot 2
- free_valid  in  2  bit0/bit1 qualify free_preg1/free_preg2
- free_preg1, free_preg2  in  PW  released pregs from retirement
- commit_count  in  2  allocations retired this cycle (0..2)
- free_count  out  PW+1  entries between speculative head and tail

## Operation
- Storage: circular array `entry[NUM_PREGS]` of PW bits. Pointers `head`, `commit_head`, `tail` are PW+1 bits wide; the MSB is the wrap bit. `free_count = tail - head`, modulo 2^(PW+1).
- Reset: `entry[i] = NUM_AREGS+i` for i < NUM_PREGS-NUM_AREGS; other entries are 0. `head = commit_head = 0`, `tail = NUM_PREGS-NUM_AREGS`.
- Allocation is compacted:
  - `need = popcount(alloc_req)`.
  - preg1 = `entry[head]`.
  - preg2 = `entry[head + alloc_req[0]]`. A lone slot-2 request receives the head entry.
- `alloc_grant = (need != 0) && (need <= free_count) && !clear && !reset`.
- On grant, `head += need` at the clock edge. With no grant, head is unchanged and partial allocation never happens.
- Frees are compacted the same way:
  - The first valid free is written at `tail`, the second at `tail+1`.
  - `tail += popcount(free_valid)`.
  - Frees are applied even during clear.
- Commit: `commit_head += commit_count` every cycle.
- Clear: `head <= commit_head + commit_count`, which includes that cycle's commit. No allocation happens that cycle.
- Simultaneous free and alloc: grant uses the pre-edge free_count. There is no bypass, so freed pregs become allocatable the next cycle.
- Wrap-around: all index arithmetic is modulo NUM_PREGS. Wrap bits distinguish full (free_count = NUM_PREGS) from empty (0).
- Illegal, simulation assertions only:
  - a free that would push free_count above NUM_PREGS
  - commit_head passing head
  - commit_count = 3

## Timing
- preg1, preg2, alloc_grant and free_count are combinational from registered state and alloc_req/clear. Zero-cycle latency, so decode samples them in the same cycle it asserts alloc_req.
- All state updates at posedge clk. Results of a cycle's alloc, free, commit or clear are visible the following cycle.
- Reset values with defaults:
  - preg1 = 16, preg2 = 16 (alloc_req = 0), or 17 with alloc_req[0] = 1
  - alloc_grant = 0
  - free_count = 48
- Reset asserted mid-operation discards all state, including a same-cycle clear or free, and reloads the reset image.

## Test plan
- Defaults. After reset, alloc_req=11 → preg1=16, preg2=17, grant=1. Next cycle free_count=46 and preg1=18.
- alloc_req=10 after reset → preg2=16, grant=1. Next cycle preg1=17, free_count=47.
- Exhaustion:
  - Allocate 47 → free_count=1.
  - alloc_req=11 → grant=0 and head unchanged.
  - alloc_req=01 → grant=1 with preg1=63. Next cycle free_count=0.
- With free_count=0, free 5 and 6 while alloc_req=11 → grant=0. Next cycle grant=1 with preg1=5, preg2=6.
- Flush:
  - Allocate 16..21 over 3 cycles.
  - Assert clear with commit_count=2 → next cycle free_count=46 and preg1=18.
- Wrap:
  - Loop alloc-2 / commit-2 / free-2 (frees return the same pregs) for 100 cycles.
  - Check free_count stays at 48 before each alloc, never underflows, and pointers wrap past index 63 with allocated values matching the freed ones in order.

Source files
------------

// File: rtl/preg_free_list_if.sv
// Decode/retire-facing bundle of the physical-register free list.
// The master side is the pipeline and the slave side is the free list.
interface preg_free_list_if #(
    parameter int NUM_PREGS = 64
);
    localparam int PW = $clog2(NUM_PREGS);

    logic          clear;
    logic [1:0]    alloc_req;
    logic          alloc_grant;
    logic [PW-1:0] preg1;
    logic [PW-1:0] preg2;
    logic [1:0]    free_valid;
    logic [PW-1:0] free_preg1;
    logic [PW-1:0] free_preg2;
    logic [1:0]    commit_count;
    logic [PW:0]   free_count;

    modport master (
        output clear, alloc_req, free_valid, free_preg1, free_preg2, commit_count,
        input  alloc_grant, preg1, preg2, free_count
    );

    modport slave (
        input  clear, alloc_req, free_valid, free_preg1, free_preg2, commit_count,
        output alloc_grant, preg1, preg2, free_count
    );
endinterface

// File: rtl/preg_free_list.sv
// Circular physical-register free list for the two-wide rename stage.
// It keeps a speculative head, a committed head for flush rollback, and a tail for retirement frees.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 16
) (
    input logic             clk,
    input logic             reset,
    preg_free_list_if.slave bus
);
    localparam int PW       = $clog2(NUM_PREGS);
    localparam int NUM_FREE = NUM_PREGS - NUM_AREGS;

    // MSB of each pointer is a wrap bit, so full and empty are distinguishable.
    typedef logic [PW:0] ptr_t;

    logic [PW-1:0] entry [NUM_PREGS];
    ptr_t          head, commit_head, tail;
    ptr_t          need, nfree, ncommit, free_count;
    logic [PW-1:0] idx2, tail_p1, first_free;
    logic          grant;

    always_comb begin
        need       = ptr_t'(bus.alloc_req[0]) + ptr_t'(bus.alloc_req[1]);
        nfree      = ptr_t'(bus.free_valid[0]) + ptr_t'(bus.free_valid[1]);
        ncommit    = ptr_t'(bus.commit_count);
        free_count = tail - head;
        // A lone slot-2 request takes the head entry.
        idx2       = head[PW-1:0] + PW'(bus.alloc_req[0]);
        tail_p1    = tail[PW-1:0] + PW'(1);
        first_free = bus.free_valid[0] ? bus.free_preg1 : bus.free_preg2;
        grant      = (need != '0) && (need <= free_count) && !bus.clear && !reset;
    end

    assign bus.preg1       = entry[head[PW-1:0]];
    assign bus.preg2       = entry[idx2];
    assign bus.alloc_grant = grant;
    assign bus.free_count  = free_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++)
                entry[i] <= (i < NUM_FREE) ? PW'(NUM_AREGS + i) : '0;
            head        <= '0;
            commit_head <= '0;
            tail        <= ptr_t'(NUM_FREE);
        end else begin
            if (nfree != '0)
                entry[tail[PW-1:0]] <= first_free;
            if (nfree == ptr_t'(2))
                entry[tail_p1] <= bus.free_preg2;
            tail        <= tail + nfree;
            commit_head <= commit_head + ncommit;
            // The rollback target includes this cycle's commit.
            if (bus.clear)
                head <= commit_head + ncommit;
            else if (grant)
                head <= head + need;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (bus.commit_count != 2'd3)
                else $error("preg_free_list: commit_count of 3");
            assert (ncommit <= ptr_t'(head - commit_head))
                else $error("preg_free_list: commit_head passes head");
            assert (int'(free_count) - (grant ? int'(need) : 0) + int'(nfree) <= NUM_PREGS)
                else $error("preg_free_list: free list overflow");
        end
    end
endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list. Expected outputs are queued as stimulus is driven,
// then popped and compared when the combinational outputs settle.
module tb_preg_free_list;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 16;

    logic clk;
    logic reset;

    preg_free_list_if #(.NUM_PREGS(NUM_PREGS)) bus ();

    preg_free_list #(.NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {S_GRANT, S_P1, S_P2, S_FC} sig_e;
    typedef struct {
        sig_e        sig;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_v(input sig_e sig, input string tag, input int val);
        exp_t e;
        e.sig = sig;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    // Let the combinational outputs settle, then drain the queued expectations.
    task automatic observe();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sig)
                S_GRANT: obs = {31'd0, bus.alloc_grant};
                S_P1:    obs = {26'd0, bus.preg1};
                S_P2:    obs = {26'd0, bus.preg2};
                default: obs = {25'd0, bus.free_count};
            endcase
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear        = 1'b0;
        bus.alloc_req    = 2'b00;
        bus.free_valid   = 2'b00;
        bus.free_preg1   = '0;
        bus.free_preg2   = '0;
        bus.commit_count = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    int mq[$];
    int a, b;

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset image
        expect_v(S_P1, "rst_preg1", 16);
        expect_v(S_P2, "rst_preg2", 16);
        expect_v(S_GRANT, "rst_grant", 0);
        expect_v(S_FC, "rst_fc", 48);
        observe();
        bus.alloc_req = 2'b01;
        expect_v(S_P2, "rst_preg2_slot1", 17);
        observe();
        bus.alloc_req = 2'b11;
        expect_v(S_P1, "dual_preg1", 16);
        expect_v(S_P2, "dual_preg2", 17);
        expect_v(S_GRANT, "dual_grant", 1);
        observe();
        cyc();
        bus.alloc_req = 2'b00;
        expect_v(S_FC, "dual_fc_after", 46);
        expect_v(S_P1, "dual_preg1_after", 18);
        observe();

        // Lone slot-2 request takes the head entry
        do_reset();
        bus.alloc_req = 2'b10;
        expect_v(S_P2, "slot2_preg2", 16);
        expect_v(S_GRANT, "slot2_grant", 1);
        observe();
        cyc();
        bus.alloc_req = 2'b00;
        expect_v(S_P1, "slot2_preg1_after", 17);
        expect_v(S_FC, "slot2_fc_after", 47);
        observe();

        // Exhaustion, continuing from one allocation
        for (int k = 0; k < 23; k++) begin
            bus.alloc_req = 2'b11;
            expect_v(S_GRANT, "exh_grant", 1);
            expect_v(S_P1, "exh_preg1", 17 + 2 * k);
            observe();
            cyc();
        end
        bus.alloc_req = 2'b00;
        expect_v(S_FC, "exh_fc1", 1);
        observe();
        bus.alloc_req = 2'b11;
        expect_v(S_GRANT, "exh_all_or_nothing", 0);
        observe();
        cyc();
        bus.alloc_req = 2'b00;
        expect_v(S_FC, "exh_head_held", 1);
        expect_v(S_P1, "exh_preg1_held", 63);
        observe();
        bus.alloc_req = 2'b01;
        expect_v(S_GRANT, "exh_last_grant", 1);
        expect_v(S_P1, "exh_last_preg1", 63);
        observe();
        cyc();
        expect_v(S_FC, "exh_empty_fc", 0);
        expect_v(S_GRANT, "exh_empty_grant", 0);
        observe();

        // Free into an empty list: freed pregs are not bypassed to this cycle's allocation
        bus.alloc_req  = 2'b11;
        bus.free_valid = 2'b11;
        bus.free_preg1 = 6'd5;
        bus.free_preg2 = 6'd6;
        expect_v(S_GRANT, "nobypass_grant", 0);
        observe();
        cyc();
        bus.free_valid = 2'b00;
        expect_v(S_GRANT, "refill_grant", 1);
        expect_v(S_P1, "refill_preg1", 5);
        expect_v(S_P2, "refill_preg2", 6);
        observe();
        cyc();
        idle();

        // Flush rollback to the committed head plus this cycle's commit
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.alloc_req = 2'b11;
            expect_v(S_P1, "flush_alloc_p1", 16 + 2 * k);
            expect_v(S_P2, "flush_alloc_p2", 17 + 2 * k);
            observe();
            cyc();
        end
        bus.clear        = 1'b1;
        bus.commit_count = 2'd2;
        expect_v(S_GRANT, "flush_no_grant", 0);
        observe();
        cyc();
        idle();
        expect_v(S_FC, "flush_fc", 46);
        expect_v(S_P1, "flush_preg1", 18);
        observe();

        // Reset overrides a same-cycle clear, free and allocation
        reset          = 1'b1;
        bus.clear      = 1'b1;
        bus.alloc_req  = 2'b11;
        bus.free_valid = 2'b11;
        bus.free_preg1 = 6'd3;
        bus.free_preg2 = 6'd4;
        expect_v(S_GRANT, "reset_grant", 0);
        observe();
        cyc();
        reset = 1'b0;
        idle();
        expect_v(S_FC, "reset_mid_fc", 48);
        expect_v(S_P1, "reset_mid_preg1", 16);
        observe();

        // Steady alloc/commit/free loop that wraps the pointers
        do_reset();
        for (int i = 16; i < 64; i++) mq.push_back(i);
        for (int it = 0; it < 100; it++) begin
            bus.alloc_req = 2'b11;
            expect_v(S_FC, "wrap_fc_pre", 48);
            expect_v(S_GRANT, "wrap_grant", 1);
            expect_v(S_P1, "wrap_preg1", mq[0]);
            expect_v(S_P2, "wrap_preg2", mq[1]);
            observe();
            a = mq.pop_front();
            b = mq.pop_front();
            cyc();
            idle();
            bus.commit_count = 2'd2;
            bus.free_valid   = 2'b11;
            bus.free_preg1   = 6'(a);
            bus.free_preg2   = 6'(b);
            expect_v(S_FC, "wrap_fc_mid", 46);
            observe();
            cyc();
            idle();
            mq.push_back(a);
            mq.push_back(b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
